// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern modes, scan/breathe
// direction, and a helper that sizes the scan position register.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // A single LED still needs a 1-bit position register.
  function automatic int pos_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler. It emits a registered one-cycle tick each time the
// counter wraps, and freezes completely while en is low.
module led_prescaler #(
  parameter int WIDTH = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [WIDTH-1:0] pre;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= en && (pre == '1);
      if (en) pre <= pre + WIDTH'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: binary count, Gray count, bouncing scan, or PWM
// breathing. The pattern advances once per prescaler tick.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LEDS     = 8,
  parameter int PRESCALE_W = 18,
  parameter int PWM_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] leds,
  output logic              tick
);

  localparam int                POS_W    = pos_width(N_LEDS);
  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(N_LEDS - 1);
  localparam logic [PWM_W-1:0]  DUTY_MAX = '1;

  mode_e             mode_q, mode_d;
  dir_e              dir_q, dir_d;
  logic [N_LEDS-1:0] step_q, step_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [PWM_W-1:0]  duty_q, duty_d;
  logic [PWM_W-1:0]  pwm_cnt;
  logic [N_LEDS-1:0] leds_d;
  logic              advance;

  led_prescaler #(
    .WIDTH (PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign advance = tick && en;

  // NOTE: every variable written here gets a default first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    duty_d = duty_q;

    if (advance) begin
      if (mode_e'(mode) != mode_q) begin
        // A mode switch only restarts the new pattern; it does not advance it.
        mode_d = mode_e'(mode);
        step_d = '0;
        pos_d  = '0;
        dir_d  = DIR_UP;
        duty_d = '0;
      end else begin
        unique case (mode_q)
          MODE_COUNT,
          MODE_GRAY: step_d = step_q + N_LEDS'(1);
          MODE_SCAN: begin
            if (N_LEDS > 1) begin
              if (dir_q == DIR_UP) begin
                if (pos_q == POS_MAX) begin
                  dir_d = DIR_DOWN;
                  pos_d = pos_q - POS_W'(1);
                end else begin
                  pos_d = pos_q + POS_W'(1);
                end
              end else begin
                if (pos_q == '0) begin
                  dir_d = DIR_UP;
                  pos_d = pos_q + POS_W'(1);
                end else begin
                  pos_d = pos_q - POS_W'(1);
                end
              end
            end
          end
          MODE_BREATHE: begin
            if (dir_q == DIR_UP) begin
              if (duty_q == DUTY_MAX) begin
                dir_d  = DIR_DOWN;
                duty_d = duty_q - PWM_W'(1);
              end else begin
                duty_d = duty_q + PWM_W'(1);
              end
            end else begin
              if (duty_q == '0) begin
                dir_d  = DIR_UP;
                duty_d = duty_q + PWM_W'(1);
              end else begin
                duty_d = duty_q - PWM_W'(1);
              end
            end
          end
        endcase
      end
    end

    // Decode from the next state so the LEDs change on the same edge as it.
    leds_d = '0;
    unique case (mode_d)
      MODE_COUNT:   leds_d = step_d;
      MODE_GRAY:    leds_d = step_d ^ (step_d >> 1);
      MODE_SCAN:    leds_d = N_LEDS'(1) << pos_d;
      MODE_BREATHE: leds_d = {N_LEDS{pwm_cnt < duty_q}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= MODE_COUNT;
      dir_q   <= DIR_UP;
      step_q  <= '0;
      pos_q   <= '0;
      duty_q  <= '0;
      pwm_cnt <= '0;
      leds    <= '0;
    end else if (en) begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      pos_q   <= pos_d;
      duty_q  <= duty_d;
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      leds    <= leds_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: four instances with small prescalers,
// expected values queued as stimulus is applied and popped per tick.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'd0;

  logic [7:0] leds8;
  logic [3:0] leds4;
  logic [0:0] leds1;
  logic [1:0] leds_b;
  logic       tick8, tick4, tick1, tick_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  int         cnt_q[$];

  always #5 clk = ~clk;

  // Edges since reset release; the first edge with rst low makes it 1.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  led_pattern_gen #(.N_LEDS(8), .PRESCALE_W(2), .PWM_W(3)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds8), .tick(tick8));
  led_pattern_gen #(.N_LEDS(4), .PRESCALE_W(2), .PWM_W(3)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds4), .tick(tick4));
  led_pattern_gen #(.N_LEDS(1), .PRESCALE_W(2), .PWM_W(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds1), .tick(tick1));
  led_pattern_gen #(.N_LEDS(2), .PRESCALE_W(4), .PWM_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .leds(leds_b), .tick(tick_b));

  task automatic do_reset(input logic [1:0] m);
    rst  = 1'b1;
    en   = 1'b1;
    mode = m;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a tick8 cycle, reports its cycle number, then steps to the
  // negedge after the edge that processes it.
  task automatic wait_tick(output int at);
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick8) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no tick within 40 cycles (required one)");
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    en   = 1'b1;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({leds8, leds4, leds1, leds_b} !== 15'd0) begin
      errors++;
      $display("FAIL reset_leds: got %h/%h/%h/%h required all 0", leds8, leds4, leds1, leds_b);
    end
    checks++;
    if ({tick8, tick4, tick1, tick_b} !== 4'd0) begin
      errors++;
      $display("FAIL reset_tick: got %b required 0000", {tick8, tick4, tick1, tick_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_count;
    int at;
    logic [7:0] e;
    do_reset(2'd0);
    for (int k = 1; k <= 256; k++) exp_q.push_back(8'(k));
    for (int k = 1; k <= 256; k++) begin
      wait_tick(at);
      if (k <= 3) begin
        checks++;
        if (at !== 4 * k) begin
          errors++;
          $display("FAIL count_tick_cycle %0d: got cycle %0d required %0d", k, at, 4 * k);
        end
      end
      e = exp_q.pop_front();
      checks++;
      if (leds8 !== e) begin
        errors++;
        $display("FAIL count_leds tick %0d: got %h required %h", k, leds8, e);
      end
    end
  endtask

  task automatic test_gray;
    int at;
    logic [7:0] e;
    logic [7:0] tbl [8] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
    do_reset(2'd1);
    foreach (tbl[i]) exp_q.push_back(tbl[i]);
    for (int k = 0; k < 8; k++) begin
      wait_tick(at);
      e = exp_q.pop_front();
      checks++;
      if (leds8 !== e) begin
        errors++;
        $display("FAIL gray_leds tick %0d: got %h required %h", k, leds8, e);
      end
    end
  endtask

  task automatic test_scan;
    int at;
    logic [7:0] e;
    logic [7:0] e1;
    logic [7:0] tbl [8] = '{8'h1, 8'h2, 8'h4, 8'h8, 8'h4, 8'h2, 8'h1, 8'h2};
    do_reset(2'd2);
    foreach (tbl[i]) begin
      exp_q.push_back(tbl[i]);
      exp1_q.push_back(8'h1);
    end
    for (int k = 0; k < 8; k++) begin
      wait_tick(at);
      e  = exp_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++;
      if ({4'd0, leds4} !== e) begin
        errors++;
        $display("FAIL scan4_leds tick %0d: got %h required %h", k, leds4, e);
      end
      checks++;
      if ({7'd0, leds1} !== e1) begin
        errors++;
        $display("FAIL scan1_leds tick %0d: got %h required %h", k, leds1, e1);
      end
    end
  endtask

  task automatic test_breathe;
    int duty_seq [15] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0};
    bit seen;
    int at;
    int e;
    int c0;
    int c1;
    do_reset(2'd3);
    foreach (duty_seq[i]) cnt_q.push_back(2 * duty_seq[i]);
    seen = 1'b0;
    at   = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick_b) begin
        seen = 1'b1;
        at   = cyc;
        break;
      end
    end
    checks++;
    if (!seen || at !== 16) begin
      errors++;
      $display("FAIL breathe_first_tick: got cycle %0d required 16", at);
    end
    // Step past the mode-switch edge; each 16-cycle window then holds one duty.
    @(negedge clk);
    for (int w = 0; w < 15; w++) begin
      c0 = 0;
      c1 = 0;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        c0 += int'(leds_b[0]);
        c1 += int'(leds_b[1]);
      end
      e = cnt_q.pop_front();
      checks++;
      if (c0 !== e || c1 !== e) begin
        errors++;
        $display("FAIL breathe_on_cycles window %0d: got %0d/%0d required %0d", w, c0, c1, e);
      end
    end
  endtask

  task automatic test_en_freeze;
    int at;
    int t0;
    logic [7:0] e;
    do_reset(2'd0);
    wait_tick(at);
    wait_tick(t0);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h03);
    en = 1'b0;
    e  = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (tick8 !== 1'b0 || leds8 !== e) begin
        errors++;
        $display("FAIL en_freeze cycle %0d: got tick %b leds %h required tick 0 leds %h", i, tick8, leds8, e);
      end
    end
    en = 1'b1;
    wait_tick(at);
    checks++;
    if (at !== t0 + 14) begin
      errors++;
      $display("FAIL en_tick_delay: got cycle %0d required %0d", at, t0 + 14);
    end
    e = exp_q.pop_front();
    checks++;
    if (leds8 !== e) begin
      errors++;
      $display("FAIL en_resume_leds: got %h required %h", leds8, e);
    end
  endtask

  task automatic test_mode_change;
    int at;
    logic [7:0] e;
    do_reset(2'd0);
    wait_tick(at);
    mode = 2'd1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (leds8 !== e) begin
      errors++;
      $display("FAIL mode_midperiod_hold: got %h required %h", leds8, e);
    end
    for (int k = 0; k < 3; k++) begin
      wait_tick(at);
      e = exp_q.pop_front();
      checks++;
      if (leds8 !== e) begin
        errors++;
        $display("FAIL mode_change_leds tick %0d: got %h required %h", k, leds8, e);
      end
    end
  endtask

  task automatic test_reset_mid_scan;
    int at;
    bit seen;
    do_reset(2'd2);
    repeat (3) wait_tick(at);
    checks++;
    if (leds4 !== 4'b0100) begin
      errors++;
      $display("FAIL scan_pos2: got %b required 0100", leds4);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tick8) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL scan_tick_timeout: no tick within 40 cycles (required one)");
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (leds4 !== 4'd0 || leds8 !== 8'd0 || tick8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got leds4 %b leds8 %h tick %b required 0/0/0", leds4, leds8, tick8);
    end
    rst = 1'b0;
    wait_tick(at);
    checks++;
    if (at !== 4) begin
      errors++;
      $display("FAIL mid_reset_first_tick: got cycle %0d required 4", at);
    end
    // Reset must have returned the mode to COUNT, so this tick is a switch.
    checks++;
    if (leds4 !== 4'b0001) begin
      errors++;
      $display("FAIL mid_reset_mode_switch: got %b required 0001", leds4);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_gray();
    test_scan();
    test_breathe();
    test_en_freeze();
    test_mode_change();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
